// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/data arbiter and byte-serial sequencer for the main-memory port
// Optional feature macro: MEM_ARB_SIGN_EXT_EN (sign-extend sub-word data loads when d_signed=1)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [LEN-1:0]        if_inst,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic                  d_signed,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LEN-1:0]        d_wdata,
  output logic                  d_ready,
  output logic [LEN-1:0]        d_rdata,
  input  logic [BYTE_SIZE-1:0]  mem_din,
  output logic [BYTE_SIZE-1:0]  mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [2:0]            n_q;
  logic [2:0]            k_q;
  logic [LEN-1:0]        wdata_q;
  logic [LEN-1:0]        asm_q;
  logic                  signed_q;
  logic                  is_data_q;
  logic                  last_was_data;

  logic                  grant_if;
  logic                  grant_d;
  logic [2:0]            d_n;
  logic [2:0]            k_nxt;
  logic [1:0]            tail_idx;
  logic [1:0]            cap_idx;
  logic [1:0]            wr_idx;
  logic [LEN-1:0]        fill;
  logic [LEN-1:0]        result;

  // Round-robin: on a tie the requester that did not get the last grant wins
  assign grant_if = if_req && (!d_req || last_was_data);
  assign grant_d  = d_req && !grant_if;

  assign k_nxt    = k_q + 3'd1;
  assign tail_idx = 2'(n_q - 3'd1);
  assign cap_idx  = 2'(k_q - 3'd1);
  assign wr_idx   = 2'(k_nxt);

  // Data transfer length in bytes; size code 3 is treated as a word
  always_comb begin
    d_n = 3'd4;
    case (d_size)
      2'd0:    d_n = 3'd1;
      2'd1:    d_n = 3'd2;
      default: d_n = 3'd4;
    endcase
  end

  // Final read value: merge the tail byte arriving now, then extend sub-word data loads
  always_comb begin
    fill = asm_q;
    fill[tail_idx*BYTE_SIZE +: BYTE_SIZE] = mem_din;
    result = fill;
    if (is_data_q) begin
      case (n_q)
        3'd1:    result = {{(LEN-BYTE_SIZE){1'b0}}, fill[BYTE_SIZE-1:0]};
        3'd2:    result = {{(LEN-2*BYTE_SIZE){1'b0}}, fill[2*BYTE_SIZE-1:0]};
        default: result = fill;
      endcase
`ifdef MEM_ARB_SIGN_EXT_EN
      if (signed_q) begin
        case (n_q)
          3'd1:    result = {{(LEN-BYTE_SIZE){fill[BYTE_SIZE-1]}}, fill[BYTE_SIZE-1:0]};
          3'd2:    result = {{(LEN-2*BYTE_SIZE){fill[2*BYTE_SIZE-1]}}, fill[2*BYTE_SIZE-1:0]};
          default: result = fill;
        endcase
      end
`endif
    end
  end

`ifndef MEM_ARB_SIGN_EXT_EN
  // Without sign extension the latched select has no consumer
  logic unused_signed;
  assign unused_signed = signed_q;
`endif

  // Arbitration, byte sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      base_q        <= '0;
      n_q           <= 3'd0;
      k_q           <= 3'd0;
      wdata_q       <= '0;
      asm_q         <= '0;
      signed_q      <= 1'b0;
      is_data_q     <= 1'b0;
      last_was_data <= 1'b1;
      if_ready      <= 1'b0;
      if_inst       <= '0;
      d_ready       <= 1'b0;
      d_rdata       <= '0;
      mem_dout      <= '0;
      mem_a         <= '0;
      mem_wr        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || grant_d) begin
            base_q        <= grant_if ? if_addr : d_addr;
            mem_a         <= grant_if ? if_addr : d_addr;
            n_q           <= grant_if ? 3'd4 : d_n;
            wdata_q       <= d_wdata;
            signed_q      <= d_signed;
            is_data_q     <= grant_d;
            last_was_data <= grant_d;
            k_q           <= 3'd0;
            busy          <= 1'b1;
            if (grant_d && d_we) begin
              state    <= WR;
              mem_wr   <= 1'b1;
              mem_dout <= d_wdata[BYTE_SIZE-1:0];
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          // mem_din now holds the byte addressed in the previous cycle
          if (k_q != 3'd0) asm_q[cap_idx*BYTE_SIZE +: BYTE_SIZE] <= mem_din;
          if (k_q == n_q - 3'd1) begin
            state <= RD_TAIL;
          end else begin
            k_q   <= k_nxt;
            mem_a <= base_q + ADDR_WIDTH'(k_nxt);
          end
        end
        RD_TAIL: begin
          asm_q <= fill;
          state <= DONE;
          if (is_data_q) begin
            d_ready <= 1'b1;
            d_rdata <= result;
          end else begin
            if_ready <= 1'b1;
            if_inst  <= result;
          end
        end
        WR: begin
          if (k_q == n_q - 3'd1) begin
            state    <= DONE;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
            d_ready  <= 1'b1;
            d_rdata  <= '0;
          end else begin
            k_q      <= k_nxt;
            mem_a    <= base_q + ADDR_WIDTH'(k_nxt);
            mem_dout <= wdata_q[wr_idx*BYTE_SIZE +: BYTE_SIZE];
          end
        end
        DONE: begin
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [16:0] if_addr;
  logic        if_ready;
  logic [31:0] if_inst;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [16:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [16:0] mem_a;
  logic        mem_wr;
  logic        busy;

  logic [7:0]  ram [0:131071];
  logic        pre_we = 1'b0;
  logic [16:0] pre_a = '0;
  logic [7:0]  pre_d = '0;

  int n_checks = 0;
  int n_errors = 0;

  int          rdy_cyc;
  bit          got_if;
  bit          got_d;
  logic [16:0] a_log  [0:19];
  logic        wr_log [0:19];
  logic [7:0]  do_log [0:19];
  logic        bz_log [0:19];

  mem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_inst  (if_inst),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_size   (d_size),
    .d_signed (d_signed),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Byte RAM: registered read, write on mem_wr; bench preload port when idle
  always @(posedge clk) begin
    mem_din <= ram[mem_a];
    if (mem_wr) ram[mem_a] <= mem_dout;
    else if (pre_we) ram[pre_a] <= pre_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [16:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  // Called in the IDLE cycle where the request is sampled (cycle 0); returns positioned at the next IDLE
  task automatic run_xfer(input int limit);
    got_if  = 1'b0;
    got_d   = 1'b0;
    rdy_cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      step();
      a_log[c]  = mem_a;
      wr_log[c] = mem_wr;
      do_log[c] = mem_dout;
      bz_log[c] = busy;
      if (if_ready || d_ready) begin
        got_if  = if_ready;
        got_d   = d_ready;
        rdy_cyc = c;
        if (if_ready) if_req = 1'b0;
        if (d_ready) d_req = 1'b0;
        break;
      end
    end
    check("ready_seen", 32'(rdy_cyc > 0), 32'd1);
    step();
  endtask

  task automatic set_data(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [16:0] a, input logic [31:0] wd);
    d_req    = 1'b1;
    d_we     = we;
    d_size   = sz;
    d_signed = sg;
    d_addr   = a;
    d_wdata  = wd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_rdy;
    logic [31:0] exp_lb;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'd0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
    step();
    preset(17'h00010, 8'hEF); preset(17'h00011, 8'hBE);
    preset(17'h00012, 8'hAD); preset(17'h00013, 8'hDE);
    preset(17'h00300, 8'h01); preset(17'h00301, 8'h02);
    preset(17'h00302, 8'h03); preset(17'h00303, 8'h04);
    preset(17'h00202, 8'h77); preset(17'h00203, 8'h77);
    preset(17'h1FFFE, 8'h11); preset(17'h1FFFF, 8'h80);
    preset(17'h00000, 8'hA1); preset(17'h00001, 8'hB2);
    preset(17'h00502, 8'h5A);

    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_d_ready",  32'(d_ready),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_mem_wr",   32'(mem_wr),   32'd0);
    check("rst_mem_a",    32'(mem_a),    32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_if_inst",  if_inst,       32'd0);
    check("rst_d_rdata",  d_rdata,       32'd0);

    // Tie right after reset: IF first, then the held data load
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 17'h00010;
    set_data(1'b0, 2'd2, 1'b0, 17'h00300, 32'h0);
    run_xfer(12);
    check("tie1_if_won", 32'(got_if), 32'd1);
    check("tie1_no_d",   32'(got_d),  32'd0);
    check("if_rdy_cyc",  32'(rdy_cyc), 32'd6);
    check("if_busy_c1",  32'(bz_log[1]), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      check("if_mem_a", 32'(a_log[c]), 32'h10 + 32'(c - 1));
      check("if_no_wr", 32'(wr_log[c]), 32'd0);
    end
    check("if_inst", if_inst, 32'hDEADBEEF);
    check("idle_busy", 32'(busy), 32'd0);
    run_xfer(12);
    check("lw_got_d",   32'(got_d),   32'd1);
    check("lw_rdy_cyc", 32'(rdy_cyc), 32'd6);
    check("lw_rdata",   d_rdata,      32'h04030201);
    check("if_inst_hold", if_inst,    32'hDEADBEEF);

    // Second tie after a data grant goes to IF again
    if_req = 1'b1; if_addr = 17'h00010;
    set_data(1'b0, 2'd2, 1'b0, 17'h00300, 32'h0);
    run_xfer(12);
    check("tie2_if_won", 32'(got_if), 32'd1);
    check("tie2_no_d",   32'(got_d),  32'd0);
    run_xfer(12);
    check("tie2_d_next", 32'(got_d),  32'd1);

    // sw
    set_data(1'b1, 2'd2, 1'b0, 17'h00100, 32'h11223344);
    run_xfer(12);
    check("sw_rdy_cyc", 32'(rdy_cyc), 32'd5);
    check("sw_got_d",   32'(got_d),   32'd1);
    for (int c = 1; c <= 4; c++) begin
      check("sw_wr",   32'(wr_log[c]), 32'd1);
      check("sw_a",    32'(a_log[c]),  32'h100 + 32'(c - 1));
      check("sw_dout", 32'(do_log[c]), (32'h11223344 >> (8 * (c - 1))) & 32'hFF);
    end
    check("sw_done_wr", 32'(wr_log[5]), 32'd0);
    check("sw_rdata",   d_rdata, 32'd0);
    check("sw_ram", {ram[17'h103], ram[17'h102], ram[17'h101], ram[17'h100]}, 32'h11223344);
    check("idle_dout", 32'(mem_dout), 32'd0);
    check("idle_wr",   32'(mem_wr),   32'd0);

    // sh only touches two bytes
    set_data(1'b1, 2'd1, 1'b0, 17'h00200, 32'hAAAA5566);
    run_xfer(12);
    check("sh_rdy_cyc", 32'(rdy_cyc), 32'd3);
    check("sh_ram", {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]}, 32'h77775566);

    // lb at top of address space, signed select
`ifdef MEM_ARB_SIGN_EXT_EN
    exp_lb = 32'hFFFFFF80;
`else
    exp_lb = 32'h00000080;
`endif
    set_data(1'b0, 2'd0, 1'b1, 17'h1FFFF, 32'h0);
    run_xfer(12);
    check("lb_rdy_cyc", 32'(rdy_cyc), 32'd3);
    check("lb_mem_a",   32'(a_log[1]), 32'h1FFFF);
    check("lb_signed",  d_rdata, exp_lb);
    set_data(1'b0, 2'd0, 1'b0, 17'h1FFFF, 32'h0);
    run_xfer(12);
    check("lbu", d_rdata, 32'h00000080);

    // lw wrapping past the top address
    set_data(1'b0, 2'd3, 1'b0, 17'h1FFFE, 32'h0);
    run_xfer(12);
    check("lw_wrap_a1", 32'(a_log[1]), 32'h1FFFE);
    check("lw_wrap_a2", 32'(a_log[2]), 32'h1FFFF);
    check("lw_wrap_a3", 32'(a_log[3]), 32'h00000);
    check("lw_wrap_a4", 32'(a_log[4]), 32'h00001);
    check("lw_wrap_rdata", d_rdata, 32'hB2A18011);

    // sb
    set_data(1'b1, 2'd0, 1'b0, 17'h00400, 32'h123456AB);
    run_xfer(12);
    check("sb_rdy_cyc", 32'(rdy_cyc), 32'd2);
    check("sb_ram", 32'(ram[17'h400]), 32'hAB);

    // Reset during WR at k=1
    set_data(1'b1, 2'd2, 1'b0, 17'h00500, 32'h55667788);
    step();
    check("rw_c1_wr", 32'(mem_wr), 32'd1);
    check("rw_c1_a",  32'(mem_a),  32'h500);
    step();
    check("rw_c2_a",  32'(mem_a),  32'h501);
    rst_n = 1'b0;
    d_req = 1'b0;
    step();
    check("rw_rst_wr",   32'(mem_wr),  32'd0);
    check("rw_rst_busy", 32'(busy),    32'd0);
    check("rw_rst_rdy",  32'(d_ready), 32'd0);
    rst_n = 1'b1;
    idle_rdy = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (d_ready) idle_rdy++;
    end
    check("rw_no_ready", 32'(idle_rdy), 32'd0);
    check("rw_ram", {8'h00, ram[17'h502], ram[17'h501], ram[17'h500]}, 32'h005A7788);
    set_data(1'b1, 2'd2, 1'b0, 17'h00600, 32'hCAFEF00D);
    run_xfer(12);
    check("rs_a1",      32'(a_log[1]),  32'h600);
    check("rs_dout1",   32'(do_log[1]), 32'h0D);
    check("rs_rdy_cyc", 32'(rdy_cyc),   32'd5);
    check("rs_ram", {ram[17'h603], ram[17'h602], ram[17'h601], ram[17'h600]}, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
